alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Iterative unsigned multiply/divide sequencer. It is the initiator on the CPU ALU operand/opcode interface.
- It drives one ALU add or subtract per cycle and consumes the ALU Result and CF to build a product, or a quotient and remainder.
- It sits beside the decoder in the execute stage and owns the ALU port only while busy. The CPU mux selects the ALU driver on busy.

Parameters:
- N, 32, operand/result width; must equal the ALU width.
- CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; sampled with start.
- opa  in  N  multiplicand or dividend; sampled with start.
- opb  in  N  multiplier or divisor; sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when results are valid.
- res_lo  out  N  product low N bits, or quotient.
- res_hi  out  N  remainder (divide); 0 for multiply.
- div0  out  1  divide by zero; valid with done, held until next start.
- alu_x  out  N  ALU X operand.
- alu_y  out  N  ALU Y operand.
- alu_sel  out  3  ALU AS2..AS0; always 3'b000 (adder).
- alu_add_sub  out  1  ALU ADD_SUB; 0 = add, 1 = subtract (X-Y).
- alu_arith  out  1  ALU Arithmetic; tied 0.
- alu_result  in  N  ALU Result.
- alu_cf  in  1  ALU carry out. For subtract, 1 means X >= Y (no borrow).

Behaviour:
- Reset (async, any state): state = IDLE; busy, done, div0 = 0; res_lo, res_hi = 0; counter = 0; alu_x, alu_y, alu_add_sub = 0.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - ALU outputs driven 0.
  - start=1 latches operands and op_div, clears div0, and goes to RUN with counter = 0.
  - Exception: op_div=1 and opb=0 goes directly to FIN with res_lo = all ones, res_hi = opa, div0 = 1.
- RUN: busy = 1; exactly N cycles, counter 0..N-1; last RUN cycle goes to FIN.
- FIN: done = 1 for exactly one cycle, busy = 0, then IDLE. Results hold until the next accepted start.
- Latency: start at cycle T gives done at T+N+1 (33 for N=32). Divide by zero gives done at T+1.
- Multiply, per RUN cycle (registers acc, mcand, mplier):
  - alu_x = acc, alu_y = mcand, alu_add_sub = 0.
  - If mplier[0]=1, acc <= alu_result.
  - mcand <<= 1, mplier >>= 1.
  - Carries beyond N bits are discarded: res_lo = (opa*opb) mod 2^N.
- Divide, per RUN cycle, restoring (registers rem, q, dvs):
  - rs = {rem[N-2:0], q[N-1]}; alu_x = rs, alu_y = dvs, alu_add_sub = 1.
  - Accept when alu_cf=1 OR rem[N-1]=1 (a shifted value ≥ 2^N always exceeds dvs).
  - Accept: rem <= alu_result, q <= {q[N-2:0], 1}.
  - Else: rem <= rs, q <= {q[N-2:0], 0}.
  - At FIN: res_lo = q, res_hi = rem.
- start while busy or in FIN is ignored; no queuing.
- Operand inputs may change freely after the start cycle.
- alu_x, alu_y and alu_add_sub are combinational from state and registers.
- alu_result and alu_cf are used the same cycle; the ALU is purely combinational.
- Reset mid-operation aborts the operation. No done pulse follows the reset.

Decomposition:
- Shared package holds:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  - ALU opcode constants: ALU_OP_ADD = 3'b000, AND = 001, OR = 010, XOR = 011, NOT = 100, LSH = 101, CSH = 110;
  - ADD_SUB_ADD = 0, ADD_SUB_SUB = 1;
  - default width N = 32.
- Single module; no sub-module is needed.
- The bench instantiates the real ALU on the alu_* ports.

Test Plan:
- Multiply: opa = 7, opb = 6 -> done at T+33; res_lo = 42, res_hi = 0, div0 = 0; busy high T+1..T+32.
- Multiply wrap: opa = 0xFFFFFFFF, opb = 2 -> res_lo = 0xFFFFFFFE.
- Divide: opa = 100, opb = 7 -> res_lo = 14, res_hi = 2.
- Divide with remainder MSB set: opa = 0xFFFFFFFF, opb = 0x80000001 -> res_lo = 1, res_hi = 0x7FFFFFFE.
- Divide by zero: opa = 0x1234, opb = 0 -> done at T+1; res_lo = 0xFFFFFFFF, res_hi = 0x1234, div0 = 1.
- Robustness:
  - start pulses at T+5 during a busy multiply are ignored; the result is unchanged.
  - reset asserted at T+10 forces IDLE and zeroes all outputs; no done follows.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// FSM state encoding, ALU opcode constants and default datapath width.
package alu_muldiv_seq_pkg;

   localparam int unsigned N_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [2:0] ALU_OP_ADD = 3'b000;
   localparam logic [2:0] ALU_OP_AND = 3'b001;
   localparam logic [2:0] ALU_OP_OR  = 3'b010;
   localparam logic [2:0] ALU_OP_XOR = 3'b011;
   localparam logic [2:0] ALU_OP_NOT = 3'b100;
   localparam logic [2:0] ALU_OP_LSH = 3'b101;
   localparam logic [2:0] ALU_OP_CSH = 3'b110;

   localparam logic ADD_SUB_ADD = 1'b0;
   localparam logic ADD_SUB_SUB = 1'b1;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply / restoring divide sequencer. Drives one
// add or subtract per cycle on the external ALU and folds the ALU result
// and carry back into its working registers for N cycles.
module alu_muldiv_seq
   import alu_muldiv_seq_pkg::*;
#(
   parameter int unsigned N  = N_DEFAULT,
   parameter int unsigned CW = 6
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         op_div,
   input  logic [N-1:0] opa,
   input  logic [N-1:0] opb,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] res_lo,
   output logic [N-1:0] res_hi,
   output logic         div0,
   output logic [N-1:0] alu_x,
   output logic [N-1:0] alu_y,
   output logic [2:0]   alu_sel,
   output logic         alu_add_sub,
   output logic         alu_arith,
   input  logic [N-1:0] alu_result,
   input  logic         alu_cf
);

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic           is_div;
   // Working registers are shared between the two operations:
   //   ra = acc (multiply) / rem (divide)
   //   rb = mcand (multiply) / dvs (divide)
   //   rc = mplier (multiply) / q (divide)
   logic [N-1:0]   ra, rb, rc;
   logic [N-1:0]   ra_nxt, rb_nxt, rc_nxt;
   logic [N-1:0]   rs;
   logic           accept;
   logic           last;
   logic           div_by_zero;

   assign rs          = {ra[N-2:0], rc[N-1]};
   // A shifted remainder that overflowed N bits always exceeds the divisor.
   assign accept      = alu_cf | ra[N-1];
   assign last        = (cnt == CW'(N - 1));
   assign div_by_zero = op_div && (opb == '0);

   // One iteration step of the working registers from the ALU response
   always_comb begin
      ra_nxt = ra;
      rb_nxt = rb;
      rc_nxt = rc;
      if (is_div) begin
         if (accept) begin
            ra_nxt = alu_result;
            rc_nxt = {rc[N-2:0], 1'b1};
         end else begin
            ra_nxt = rs;
            rc_nxt = {rc[N-2:0], 1'b0};
         end
      end else begin
         if (rc[0]) ra_nxt = alu_result;
         rb_nxt = rb << 1;
         rc_nxt = rc >> 1;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = div_by_zero ? FIN : RUN;
         RUN:  if (last)  state_nxt = FIN;
         FIN:             state_nxt = IDLE;
         default:         state_nxt = IDLE;
      endcase
   end

   // Status and ALU drive, combinational from state and registers
   always_comb begin
      busy        = (state == RUN);
      done        = (state == FIN);
      alu_sel     = ALU_OP_ADD;
      alu_arith   = 1'b0;
      alu_x       = '0;
      alu_y       = '0;
      alu_add_sub = ADD_SUB_ADD;
      if (state == RUN) begin
         alu_x       = is_div ? rs : ra;
         alu_y       = rb;
         alu_add_sub = is_div ? ADD_SUB_SUB : ADD_SUB_ADD;
      end
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         is_div <= 1'b0;
         ra     <= '0;
         rb     <= '0;
         rc     <= '0;
         res_lo <= '0;
         res_hi <= '0;
         div0   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  is_div <= op_div;
                  cnt    <= '0;
                  div0   <= 1'b0;
                  if (div_by_zero) begin
                     div0   <= 1'b1;
                     res_lo <= '1;
                     res_hi <= opa;
                  end else begin
                     ra <= '0;
                     rb <= op_div ? opb : opa;
                     rc <= op_div ? opa : opb;
                  end
               end
            end
            RUN: begin
               ra  <= ra_nxt;
               rb  <= rb_nxt;
               rc  <= rc_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  res_lo <= is_div ? rc_nxt : ra_nxt;
                  res_hi <= is_div ? ra_nxt : '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural ALU on the
// alu_* ports and an arithmetic reference model for products/quotients.
module tb_alu_muldiv_seq;
   import alu_muldiv_seq_pkg::*;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          op_div = 1'b0;
   logic [N-1:0]  opa = '0, opb = '0;
   logic          busy, done, div0;
   logic [N-1:0]  res_lo, res_hi;
   logic [N-1:0]  alu_x, alu_y, alu_result;
   logic [2:0]    alu_sel;
   logic          alu_add_sub, alu_arith, alu_cf;

   int checks = 0;
   int errors = 0;

   alu_muldiv_seq #(.N(N), .CW(6)) dut (
      .clk(clk), .reset(reset), .start(start), .op_div(op_div),
      .opa(opa), .opb(opb), .busy(busy), .done(done),
      .res_lo(res_lo), .res_hi(res_hi), .div0(div0),
      .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel),
      .alu_add_sub(alu_add_sub), .alu_arith(alu_arith),
      .alu_result(alu_result), .alu_cf(alu_cf)
   );

   always #5 clk = ~clk;

   // Behavioural combinational ALU
   always_comb begin
      alu_result = '0;
      alu_cf     = 1'b0;
      case (alu_sel)
         ALU_OP_ADD:
            if (alu_add_sub)
               {alu_cf, alu_result} = {1'b0, alu_x} + {1'b0, ~alu_y} + 33'd1;
            else
               {alu_cf, alu_result} = {1'b0, alu_x} + {1'b0, alu_y};
         ALU_OP_AND: alu_result = alu_x & alu_y;
         ALU_OP_OR:  alu_result = alu_x | alu_y;
         ALU_OP_XOR: alu_result = alu_x ^ alu_y;
         ALU_OP_NOT: alu_result = ~alu_x;
         ALU_OP_LSH: {alu_cf, alu_result} = {alu_x, 1'b0};
         ALU_OP_CSH: alu_result = {alu_x[N-2:0], alu_x[N-1]};
         default:    alu_result = '0;
      endcase
   end

   // Reference: {res_hi, res_lo}
   function automatic logic [63:0] ref_model(input logic d, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      if (!d) begin
         p = 64'(a) * 64'(b);
         return {32'd0, p[31:0]};
      end
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int glitch_at);
      logic [63:0] expv;
      int cyc, bad, exp_lat;
      expv    = ref_model(d, a, b);
      exp_lat = (d && b == 0) ? 1 : N + 1;
      @(negedge clk);
      op_div = d; opa = a; opb = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; opa = $urandom; opb = $urandom; op_div = 1'($urandom);
      cyc = 1; bad = 0;
      while (!done && cyc < 200) begin
         if (busy !== (cyc < exp_lat)) bad++;
         if (alu_sel !== 3'b000 || alu_arith !== 1'b0) bad++;
         @(negedge clk);
         cyc++;
         start = (cyc == glitch_at);
         if (start) begin opa = $urandom; opb = $urandom_range(3, 0); end
      end
      start = 1'b0;
      chk("latency", 64'(cyc), 64'(exp_lat));
      chk("busy_alu_seq", 64'(bad), 0);
      chk("res_lo", 64'(res_lo), 64'(expv[31:0]));
      chk("res_hi", 64'(res_hi), 64'(expv[63:32]));
      chk("div0", 64'(div0), 64'(d && b == 0));
      chk("busy_at_done", 64'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 0);
      chk("idle_alu", {alu_x, alu_y[30:0], alu_add_sub}, 0);
      chk("res_hold", {res_hi, res_lo}, expv);
   endtask

   initial begin
      int n_done;
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_status", {61'd0, busy, done, div0}, 0);
      chk("rst_res", {res_hi, res_lo}, 0);
      chk("rst_alu", {alu_x, alu_y[30:0], alu_add_sub}, 0);
      reset = 1'b0;

      // Directed cases
      run_op(1'b0, 32'd7, 32'd6, 0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 0);
      run_op(1'b1, 32'd100, 32'd7, 0);
      run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 0);
      run_op(1'b1, 32'h1234, 32'd0, 0);
      run_op(1'b0, 32'd0, 32'hDEAD_BEEF, 0);
      run_op(1'b1, 32'd5, 32'd9, 0);
      run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0);

      // Start pulses while busy are ignored
      run_op(1'b0, 32'h1357_9BDF, 32'h0246_8ACE, 5);
      run_op(1'b1, 32'hCAFE_F00D, 32'h0000_1234, 20);

      // Reset mid-operation
      @(negedge clk);
      op_div = 1'b0; opa = 32'd123; opb = 32'd456; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_status", {61'd0, busy, done, div0}, 0);
      chk("midrst_res", {res_hi, res_lo}, 0);
      chk("midrst_alu", {alu_x, alu_y[30:0], alu_add_sub}, 0);
      reset = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("no_done_after_rst", 64'(n_done), 0);
      run_op(1'b0, 32'd12345, 32'd678, 0);

      // Randomized operations
      for (int i = 0; i < 24; i++) begin
         logic d;
         logic [31:0] a, b;
         d = 1'($urandom);
         a = $urandom;
         case ($urandom_range(3, 0))
            0: b = 32'd0;
            1: b = $urandom_range(15, 1);
            default: b = $urandom;
         endcase
         if (!d && b == 0) b = $urandom;
         run_op(d, a, b, (i % 3 == 0) ? int'($urandom_range(30, 2)) : 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
